// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults and sizes for the FIFO arbitration controller
package fifo_arb_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int REQ_IDX_W      = $clog2(NUM_REQ_DEF);
    localparam int OUT_BUF_DEPTH  = 2;
endpackage

// File: rtl/fifo_arb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
        end
    end
    assign grant = (|req) ? N'(1) << idx : '0;
endmodule

// File: rtl/fifo_arb_ctrl.sv
// fifo_arb_ctrl: round-robin FIFO write arbitration plus 2-entry valid/ready read drain
module fifo_arb_ctrl
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          fifo_wren,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    input  logic                          fifo_full,
    output logic                          fifo_rden,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata,
    input  logic                          fifo_empty,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready
);
    logic [IDX_W-1:0]      rr_ptr, win;
    logic [NUM_REQ-1:0]    grant;
    logic                  inflight, pop;
    logic [1:0]            occ, occ_n;
    logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;

    rr_arbiter #(.N(NUM_REQ), .W(IDX_W)) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (win)
    );

    always_comb begin
        fifo_wren  = !rst && (|req_valid) && !fifo_full;
        req_ack    = fifo_wren ? grant : '0;
        grant_id   = win;
        fifo_wdata = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= '0;
        else if (fifo_wren) rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
    end

    // A returning read lands at the slot just past the post-pop occupancy
    always_comb begin
        pop       = out_valid && out_ready;
        fifo_rden = !rst && !fifo_empty &&
                    (int'(occ) + int'(inflight) - int'(pop) < OUT_BUF_DEPTH);
        occ_n     = occ + {1'b0, inflight} - {1'b0, pop};
        head_n    = (inflight && occ_n == 2'd1) ? fifo_rdata : pop ? tail : head;
        tail_n    = (inflight && occ_n == 2'd2) ? fifo_rdata : tail;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= fifo_rden;
            occ      <= occ_n;
            head     <= head_n;
            tail     <= tail_n;
        end
    end

    assign out_valid = (occ != 2'd0);
    assign out_data  = head;
endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb_fifo_arb_ctrl: scoreboard bench with an 8-deep registered-read FIFO model
module tb_fifo_arb_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_ack;
    logic [1:0]    grant_id;
    logic          fifo_wren, fifo_full, fifo_rden, fifo_empty;
    logic [DW-1:0] fifo_wdata;
    logic [DW-1:0] fifo_rdata = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          force_full = 1'b0;

    int checks = 0;
    int errors = 0;

    fifo_arb_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .grant_id  (grant_id),
        .fifo_wren (fifo_wren),
        .fifo_wdata(fifo_wdata),
        .fifo_full (fifo_full),
        .fifo_rden (fifo_rden),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, updated only on rden while non-empty
    logic [DW-1:0] fq[$];
    int fcnt = 0;
    always @(posedge clk) begin
        if (fifo_rden && fq.size() > 0) begin
            fifo_rdata <= fq[0];
            fq.pop_front();
        end
        if (fifo_wren && fq.size() < 8) fq.push_back(fifo_wdata);
        fcnt <= fq.size();
    end
    assign fifo_empty = (fcnt == 0);
    assign fifo_full  = force_full || (fcnt >= 8);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboards
    int            wid[$];
    logic [DW-1:0] wdat[$];
    logic [DW-1:0] rq[$];
    int            e_id;
    logic [DW-1:0] e_wd, e_rd;

    always @(negedge clk) begin
        if (!rst && fifo_wren) begin
            if (wid.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: grant_id %0d data %0h, none expected", grant_id, fifo_wdata);
            end else begin
                e_id = wid.pop_front();
                e_wd = wdat.pop_front();
                chk("grant_id", 32'(grant_id), 32'(e_id));
                chk("fifo_wdata", 32'(fifo_wdata), 32'(e_wd));
                chk("req_ack", 32'(req_ack), 32'(1 << e_id));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: out_data %0h, none expected", out_data);
            end else begin
                e_rd = rq.pop_front();
                chk("out_data", 32'(out_data), 32'(e_rd));
            end
        end
    end

    task automatic expect_wr(input int id, input logic [DW-1:0] d);
        wid.push_back(id);
        wdat.push_back(d);
        rq.push_back(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_first, rd_last, rd_cnt, o_first, o_last, o_cnt, unstable;
        // reset state, with requests present: wren must stay low
        req_valid = 4'b1111;
        req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_wren", 32'(fifo_wren), 0);
        chk("rst_rden", 32'(fifo_rden), 0);
        chk("rst_req_ack", 32'(req_ack), 0);
        tick();
        rst = 1'b0;

        // all four writers: 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) expect_wr(i % 4, 8'(8'hA0 + i % 4));
        out_ready = 1'b1;
        repeat (8) tick();
        req_valid = '0;
        repeat (8) tick();

        // sparse requests 1010 from rr_ptr=0: 1,3,1
        req_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        req_valid = 4'b1010;
        expect_wr(1, 8'hB1);
        expect_wr(3, 8'hB3);
        expect_wr(1, 8'hB1);
        repeat (3) tick();
        req_valid = '0;
        repeat (6) tick();

        // FIFO full for 3 cycles: pointer frozen at 2
        req_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        force_full = 1'b1;
        req_valid  = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            chk("full_wren", 32'(fifo_wren), 0);
            chk("full_ack", 32'(req_ack), 0);
            tick();
        end
        force_full = 1'b0;
        expect_wr(2, 8'hC2);
        tick();
        req_valid = '0;
        repeat (10) tick();

        // 0x11,0x22,0x33 via writer 0 (rr_ptr=3 wraps to 0), timing of rden/out
        expect_wr(0, 8'h11);
        expect_wr(0, 8'h22);
        expect_wr(0, 8'h33);
        rd_first = -1; rd_last = -1; rd_cnt = 0;
        o_first = -1; o_last = -1; o_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 3) ? 4'b0001 : 4'b0000;
            req_data  = {24'h0, 8'(8'h11 * (k + 1))};
            @(negedge clk);
            if (fifo_rden) begin
                if (rd_first < 0) rd_first = k;
                rd_last = k;
                rd_cnt++;
            end
            if (out_valid && out_ready) begin
                if (o_first < 0) o_first = k;
                o_last = k;
                o_cnt++;
            end
            tick();
        end
        chk("t4_rden_first", 32'(rd_first), 1);
        chk("t4_rden_last", 32'(rd_last), 3);
        chk("t4_rden_cnt", 32'(rd_cnt), 3);
        chk("t4_out_first", 32'(o_first), 3);
        chk("t4_out_last", 32'(o_last), 5);
        chk("t4_out_cnt", 32'(o_cnt), 3);

        // out_ready low with 5 words: exactly 2 reads, head stable
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_wr(1, 8'(8'h51 + i));
        rd_cnt = 0;
        unstable = 0;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 5) ? 4'b0010 : 4'b0000;
            req_data  = {16'h0, 8'(8'h51 + k), 8'h0};
            @(negedge clk);
            if (fifo_rden) rd_cnt++;
            if (k >= 3 && (!out_valid || out_data != 8'h51)) unstable++;
            tick();
        end
        chk("t5_rden_cnt", 32'(rd_cnt), 2);
        chk("t5_head_unstable", 32'(unstable), 0);
        chk("t5_out_valid", 32'(out_valid), 1);
        chk("t5_out_data", 32'(out_data), 32'h51);
        out_ready = 1'b1;
        repeat (12) tick();

        // reset with two words buffered: they are dropped, FIFO keeps the rest
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_wr(2, 8'(8'h61 + i));
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 5) ? 4'b0100 : 4'b0000;
            req_data  = {8'h0, 8'(8'h61 + k), 16'h0};
            tick();
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_rden", 32'(fifo_rden), 0);
        chk("t6_wren", 32'(fifo_wren), 0);
        chk("t6_ack", 32'(req_ack), 0);
        void'(rq.pop_front());
        void'(rq.pop_front());
        tick();
        rst = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;

        for (int i = 0; i < 50 && (rq.size() != 0 || wid.size() != 0); i++) tick();
        chk("rd_left", 32'(rq.size()), 0);
        chk("wr_left", 32'(wid.size()), 0);
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
